// File: rtl/score_pkg.sv
// Shared types and constants for the score display.
// FSM state, display saturation limit and segment table.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam int unsigned MAX_DISP = 9999;
  localparam int unsigned N_STEP   = 14;

  // {dp,g,f,e,d,c,b,a}, active-low, dp off
  localparam logic [7:0] SEG_TAB [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [15:0] dd_adj(
    input logic [15:0] b
  );
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// BCD digit to active-low 7-segment pattern.
// Blank forces every segment off.
module seg7_dec
  import score_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'hFF;
    if (!blank && digit <= 4'd9)
      seg = SEG_TAB[digit];
  end

endmodule

// File: rtl/score_display.sv
// Score to 4-digit multiplexed 7-seg display via double-dabble.
// SCORE_DISPLAY_BLANK_EN blanks leading zero digits.
module score_display
  import score_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk_main,
  input  logic        rst_n,
  input  logic [15:0] score,
  output logic [7:0]  ssd,
  output logic [3:0]  ssd_an,
  output logic        bcd_valid,
  output logic        busy,
  output logic        ovf
);

  state_t      state;
  state_t      state_nx;
  logic [15:0] last_score;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [3:0]  cnt;
  logic [15:0] disp;
  logic [15:0] pre;
  logic [1:0]  idx;
  logic [3:0]  cur;
  logic        blank;
  logic [7:0]  seg;
  logic [13:0] sat;
  logic        chg;
  logic        step_done;
  logic        wrap;

  assign chg       = (score != last_score);
  assign step_done = (cnt == 4'(N_STEP));
  assign wrap      = (pre == 16'(SCAN_DIV - 1));
  assign sat       = (score > 16'(MAX_DISP))
                   ? 14'(MAX_DISP) : score[13:0];

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (chg) state_nx = CONV;
      CONV:    if (step_done) state_nx = LOAD;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    bcd_valid = (state == LOAD);
  end

  // cnt counts completed steps; LOAD follows once it reaches 14
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      last_score <= '0;
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      disp       <= '0;
      ovf        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (chg) begin
          last_score <= score;
          bin        <= sat;
          bcd        <= '0;
          cnt        <= '0;
        end
        CONV: if (!step_done) begin
          {bcd, bin} <= {dd_adj(bcd), bin} << 1;
          cnt        <= cnt + 4'd1;
        end
        LOAD: begin
          disp <= bcd;
          ovf  <= (last_score > 16'(MAX_DISP));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= wrap ? 16'd0 : pre + 16'd1;
      if (wrap) idx <= idx + 2'd1;
    end
  end

`ifdef SCORE_DISPLAY_BLANK_EN
  logic z3, z2, z1;
  assign z3 = (disp[15:12] == 4'd0);
  assign z2 = z3 && (disp[11:8] == 4'd0);
  assign z1 = z2 && (disp[7:4] == 4'd0);
`endif

  always_comb begin
    cur   = disp[3:0];
    blank = 1'b0;
    unique case (1'b1)
      (idx == 2'd0): cur = disp[3:0];
      (idx == 2'd1): cur = disp[7:4];
      (idx == 2'd2): cur = disp[11:8];
      (idx == 2'd3): cur = disp[15:12];
      default:       cur = disp[3:0];
    endcase
`ifdef SCORE_DISPLAY_BLANK_EN
    unique case (1'b1)
      (idx == 2'd1): blank = z1;
      (idx == 2'd2): blank = z2;
      (idx == 2'd3): blank = z3;
      default:       blank = 1'b0;
    endcase
`endif
  end

  seg7_dec u_dec (
    .digit (cur),
    .blank (blank),
    .seg   (seg)
  );

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      ssd_an <= 4'b1110;
      ssd    <= 8'hC0;
    end else begin
      ssd_an <= ~(4'b0001 << idx);
      ssd    <= seg;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display with SCAN_DIV=4.
// Expected digits are queued at stimulus and popped per bcd_valid.
module tb_score_display;

  logic        clk_main = 1'b0;
  logic        rst_n    = 1'b0;
  logic [15:0] score    = '0;
  logic [7:0]  ssd;
  logic [3:0]  ssd_an;
  logic        bcd_valid;
  logic        busy;
  logic        ovf;

  always #5 clk_main = ~clk_main;

  score_display #(.SCAN_DIV(4)) dut (
    .clk_main  (clk_main),
    .rst_n     (rst_n),
    .score     (score),
    .ssd       (ssd),
    .ssd_an    (ssd_an),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .ovf       (ovf)
  );

`ifdef SCORE_DISPLAY_BLANK_EN
  localparam logic [7:0] BLANK = 8'hFF;
`else
  localparam logic [7:0] BLANK = 8'hC0;
`endif

  logic [7:0]  segtab [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  logic [3:0]  anseq [5] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110
  };

  int          n_vec  = 0;
  int          n_bad  = 0;
  int          pulses = 0;
  bit          pend   = 0;
  logic [16:0] sb [$];
  logic [16:0] sb_exp;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(
    input logic [15:0] s
  );
    int v;
    v = (s > 16'd9999) ? 9999 : int'(s);
    return {s > 16'd9999,
            4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // digits land one edge after the bcd_valid cycle
  always @(negedge clk_main) begin
    if (pend) begin
      check("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        sb_exp = sb.pop_front();
        check("digits", {ovf, dut.disp}, 32'(sb_exp));
      end
    end
    pend = rst_n && bcd_valid;
    if (rst_n && bcd_valid) pulses++;
  end

  task automatic conv(input logic [15:0] s);
    int n;
    int bv;
    @(negedge clk_main);
    score = s;
    sb.push_back(model(s));
    @(posedge clk_main); #1;
    check("busy_start", 32'(busy), 1);
    n  = 0;
    bv = -1;
    while (busy && n < 40) begin
      n++;
      @(posedge clk_main); #1;
      if (bcd_valid && bv < 0) bv = n;
    end
    check("busy_len", n, 16);
    check("valid_at", bv, 15);
    repeat (2) @(negedge clk_main);
  endtask

  task automatic seg_at(
    input string      tag,
    input int         d,
    input logic [7:0] exp
  );
    logic [3:0] want;
    int k;
    want = ~(4'b0001 << d);
    k = 0;
    while (ssd_an !== want && k < 40) begin
      @(negedge clk_main);
      k++;
    end
    check({tag, "_an"}, 32'(ssd_an), 32'(want));
    check(tag, 32'(ssd), 32'(exp));
  endtask

  initial begin
    int p0;
    int k;
    logic [3:0] prev;

    repeat (3) @(posedge clk_main);
    #1;
    check("rst_an", 32'(ssd_an), 32'hE);
    check("rst_ssd", 32'(ssd), 32'hC0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(bcd_valid), 0);
    check("rst_ovf", 32'(ovf), 0);
    @(negedge clk_main);
    rst_n = 1'b1;
    repeat (20) @(posedge clk_main);
    #1;
    check("idle_pulses", pulses, 0);
    check("idle_busy", 32'(busy), 0);

    conv(16'd1234);
    seg_at("d0_1234", 0, segtab[4]);
    seg_at("d1_1234", 1, segtab[3]);
    seg_at("d2_1234", 2, segtab[2]);
    seg_at("d3_1234", 3, segtab[1]);

    conv(16'd65535);
    check("ovf_set", 32'(ovf), 1);
    seg_at("d3_9999", 3, segtab[9]);
    conv(16'd42);
    check("ovf_clr", 32'(ovf), 0);

    p0 = pulses;
    @(negedge clk_main);
    score = 16'd100;
    sb.push_back(model(16'd100));
    @(posedge clk_main);
    repeat (5) @(posedge clk_main);
    @(negedge clk_main);
    score = 16'd200;
    sb.push_back(model(16'd200));
    k = 0;
    while ((pulses - p0) < 2 && k < 80) begin
      @(negedge clk_main);
      k++;
    end
    repeat (3) @(negedge clk_main);
    check("two_pulses", pulses - p0, 2);
    check("sb_drained", sb.size(), 0);

    prev = ssd_an;
    k = 0;
    while (k < 40) begin
      @(negedge clk_main);
      k++;
      if (ssd_an == 4'b1110 && prev != 4'b1110) break;
      prev = ssd_an;
    end
    check("an_sync", 32'(ssd_an), 32'hE);
    for (int i = 1; i < 5; i++) begin
      repeat (2) @(negedge clk_main);
      check("an_hold", 32'(ssd_an), 32'(anseq[i-1]));
      repeat (2) @(negedge clk_main);
      check("an_step", 32'(ssd_an), 32'(anseq[i]));
    end

    conv(16'd7);
    seg_at("d0_7", 0, segtab[7]);
    seg_at("d1_7", 1, BLANK);
    seg_at("d3_7", 3, BLANK);

    @(negedge clk_main);
    score = 16'd5555;
    sb.push_back(model(16'd5555));
    @(posedge clk_main);
    repeat (5) @(posedge clk_main);
    #2;
    score = 16'd9;
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_valid", 32'(bcd_valid), 0);
    check("mid_an", 32'(ssd_an), 32'hE);
    check("mid_ssd", 32'(ssd), 32'hC0);
    check("mid_disp", 32'(dut.disp), 0);
    check("mid_ovf", 32'(ovf), 0);
    sb.delete();
    pend = 0;
    p0 = pulses;
    @(negedge clk_main);
    rst_n = 1'b1;
    sb.push_back(model(16'd9));
    @(posedge clk_main); #1;
    check("first_edge", 32'(busy), 1);
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk_main); #1;
      k++;
    end
    repeat (3) @(negedge clk_main);
    check("post_rst_pulse", pulses - p0, 1);
    check("sb_final", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, sets the number of clk_main cycles each digit stays lit during scanning; legal range 2..65535.
REQ-002 clk_main  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 score  input  16  unsigned binary score from the scoring stage, sampled every cycle.
REQ-005 ssd  output  8  segment drive {dp,g,f,e,d,c,b,a}, active-low.
REQ-006 ssd_an  output  4  digit anode select, active-low, one-hot-zero; bit 0 is the ones digit.
REQ-007 bcd_valid  output  1  one-cycle pulse when newly converted digits are loaded into the display registers.
REQ-008 busy  output  1  high while a conversion is in progress (CONV or LOAD).
REQ-009 ovf  output  1  high while the displayed value is saturated because the source score exceeded 9999.

Function
REQ-010 The FSM SHALL have the states IDLE, CONV and LOAD.
REQ-011 In IDLE, when score differs from last_score, the block SHALL latch score into last_score, load min(score,9999) into a 14-bit binary shift field, clear a 16-bit BCD field, clear the iteration counter, and enter CONV on the next edge.
REQ-012 In CONV, each cycle SHALL perform one double-dabble step: add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by 1; after the 14th step the FSM SHALL enter LOAD.
REQ-013 In LOAD, the block SHALL copy the 4 BCD nibbles into the display registers, set ovf = (last_score > 9999), pulse bcd_valid for exactly this cycle, and return to IDLE.
REQ-014 Latency SHALL be 16 cycles: a change sampled in IDLE at edge N SHALL appear in the display registers at edge N+16.
REQ-015 Score changes during CONV or LOAD SHALL NOT disturb the conversion in progress; the newest value SHALL be compared against last_score in the following IDLE cycle and converted then.
REQ-016 busy SHALL equal (state != IDLE).
REQ-017 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; on each wrap the 2-bit digit index SHALL advance, wrapping from 3 to 0.
REQ-018 ssd_an SHALL drive low only the bit selected by the digit index; ssd SHALL show the 7-segment pattern of the selected display digit with dp = 1 (off).
REQ-019 The 7-seg patterns for values 0-9 SHALL be C0,F9,A4,B0,99,92,82,F8,80,90 (hex, dp included); BCD nibbles never exceed 9.
REQ-020 ssd and ssd_an SHALL be registered, i.e. one cycle behind the digit index.

Reset
REQ-021 With rst_n low, at any time including mid-CONV: state=IDLE, last_score=0, display digits=0, prescaler=0, digit index=0, ssd_an=4'b1110, ssd=8'hC0, bcd_valid=0, busy=0, ovf=0.
REQ-022 After release, a nonzero score SHALL start a conversion on the first edge.

Configuration
REQ-023 Macro SCORE_DISPLAY_BLANK_EN: when defined, the display SHALL show 8'hFF for any digit above the most significant nonzero digit (digit 0 is always shown); when undefined, all four digits SHALL always be shown, including leading zeros.

Structure
REQ-024 Package score_pkg SHALL hold the FSM state type, the MAX_DISP=9999 constant and the 10-entry segment pattern table.
REQ-025 The combinational sub-module seg7_dec (4-bit digit plus blank flag in, 8-bit ssd pattern out) SHALL be instantiated once.

Verification
REQ-026 Reset: hold rst_n low, then release with score=0 -> ssd_an=1110, ssd=C0, busy=0, and no bcd_valid pulse.
REQ-027 score=1234 -> busy high for 16 cycles, bcd_valid pulses at edge N+16, digits 4,3,2,1; with SCAN_DIV=4, ssd is 99 on digit 0 and F9 on digit 3.
REQ-028 score=65535 -> digits 9,9,9,9 and ovf=1; then score=42 -> ovf=0 after conversion.
REQ-029 score=100 then score=200 at cycle 5 of CONV -> 100 loaded first, then a second conversion loads 200; two bcd_valid pulses total.
REQ-030 SCAN_DIV=4 -> ssd_an sequence 1110,1101,1011,0111,1110, changing every 4 cycles.
REQ-031 score=7 -> digits 1-3 show FF with SCORE_DISPLAY_BLANK_EN defined and C0 without it; rst_n low mid-CONV -> REQ-021 values immediately.
